// File: rtl/wb_slave_mux_if.sv
// Wishbone bus bundle for wb_slave_mux: master-side port plus the shared/one-hot slave side.
// The "slave" modport is the multiplexer's view; "master" is the environment's view.
interface wb_slave_mux_if #(
    parameter int N_SLAVES = 4
);
    logic [31:0]             m_adr_i;
    logic [31:0]             m_dat_i;
    logic                    m_we_i;
    logic [3:0]              m_sel_i;
    logic                    m_stb_i;
    logic [31:0]             m_dat_o;
    logic                    m_ack_o;
    logic                    m_err_o;

    logic [31:0]             s_adr_o;
    logic [31:0]             s_dat_o;
    logic                    s_we_o;
    logic [3:0]              s_sel_o;
    logic [N_SLAVES-1:0]     s_stb_o;
    logic [32*N_SLAVES-1:0]  s_dat_i;
    logic [N_SLAVES-1:0]     s_ack_i;
    logic [N_SLAVES-1:0]     s_err_i;

    modport slave (
        input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o
    );
endinterface

// File: rtl/wb_slave_mux.sv
// Wishbone slave multiplexer: decodes the master address into N_SLAVES windows and runs one
// transfer at a time. Define WB_MUX_TIMEOUT_EN to add the unresponsive-slave timeout.
module wb_slave_mux #(
    parameter int          N_SLAVES  = 4,
    parameter int          WIN_BITS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int          TIMEOUT   = 255
) (
    input logic           clk_i,
    input logic           rstn_i,
    wb_slave_mux_if.slave bus
);
    localparam int IDX_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int DEC_LSB = WIN_BITS + IDX_W;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q;
    logic [31:0]         adr_q;
    logic [31:0]         wdat_q;
    logic [31:0]         rdat_q;
    logic                we_q;
    logic [3:0]          sel_q;
    logic [N_SLAVES-1:0] stb_q;
    logic [IDX_W-1:0]    idx_q;
    logic                ack_q;
    logic                err_q;
    logic                pend_q;

    logic [IDX_W-1:0]    req_idx;
    logic                idx_ok;
    logic                hit;
    logic                sel_ack;
    logic                sel_err;
    logic [31:0]         sel_dat;

`ifdef WB_MUX_TIMEOUT_EN
    logic [15:0]         cnt_q;
    logic [15:0]         cnt_d;
    logic                timeout;

    assign cnt_d   = cnt_q + 16'd1;
    assign timeout = (cnt_q == 16'(TIMEOUT - 1));
`endif

    assign req_idx = bus.m_adr_i[DEC_LSB-1:WIN_BITS];

    generate
        if (N_SLAVES == (1 << IDX_W)) begin : g_full
            assign idx_ok = 1'b1;
        end else begin : g_part
            assign idx_ok = (32'(req_idx) < 32'(N_SLAVES));
        end
    endgenerate

    assign hit = (bus.m_adr_i[31:DEC_LSB] == BASE_ADDR[31:DEC_LSB]) && idx_ok;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (idx_q == k[IDX_W-1:0]) begin
                sel_ack = bus.s_ack_i[k];
                sel_err = bus.s_err_i[k];
                sel_dat = bus.s_dat_i[32*k +: 32];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            stb_q   <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
`ifdef WB_MUX_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            stb_q <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.m_stb_i) begin
                        adr_q  <= bus.m_adr_i;
                        wdat_q <= bus.m_dat_i;
                        we_q   <= bus.m_we_i;
                        sel_q  <= bus.m_sel_i;
                        idx_q  <= req_idx;
                        if (hit) begin
                            stb_q[req_idx] <= 1'b1;
`ifdef WB_MUX_TIMEOUT_EN
                            cnt_q          <= '0;
`endif
                            state_q        <= BUSY;
                        end else begin
                            pend_q  <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                BUSY: begin
                    // Error wins over a simultaneous ack from the same slave.
                    if (sel_err) begin
                        err_q   <= 1'b1;
                        rdat_q  <= '0;
                        state_q <= RESP;
                    end else if (sel_ack) begin
                        ack_q   <= 1'b1;
                        rdat_q  <= sel_dat;
                        state_q <= RESP;
                    end
`ifdef WB_MUX_TIMEOUT_EN
                    else if (timeout) begin
                        pend_q  <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
`endif
                end
                RESP: begin
                    // Decode misses and timeouts spend one extra RESP cycle before the err pulse.
                    if (pend_q) begin
                        err_q  <= 1'b1;
                        rdat_q <= '0;
                        pend_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_dat_o = rdat_q;
    assign bus.m_ack_o = ack_q;
    assign bus.m_err_o = err_q;
    assign bus.s_adr_o = adr_q;
    assign bus.s_dat_o = wdat_q;
    assign bus.s_we_o  = we_q;
    assign bus.s_sel_o = sel_q;
    assign bus.s_stb_o = stb_q;
endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux: 4 slaves, 256-byte windows at 0xF000_0000, TIMEOUT=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wb_slave_mux;
    localparam int N = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses;

    wb_slave_mux_if #(.N_SLAVES(N)) bus ();

    wb_slave_mux #(
        .N_SLAVES (N),
        .WIN_BITS (8),
        .BASE_ADDR(32'hF000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic master_req(input logic [31:0] adr, input logic [31:0] dat,
                              input logic we, input logic [3:0] sel);
        bus.m_adr_i = adr;
        bus.m_dat_i = dat;
        bus.m_we_i  = we;
        bus.m_sel_i = sel;
        bus.m_stb_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_we_i  = 1'b0;
        bus.m_sel_i = '0;
        bus.m_stb_i = 1'b0;
        bus.s_dat_i = '0;
        bus.s_ack_i = '0;
        bus.s_err_i = '0;

        // Reset state
        repeat (2) cyc();
        check("rst_ack", bus.m_ack_o, 0);
        check("rst_err", bus.m_err_o, 0);
        check("rst_stb", bus.s_stb_o, 0);
        check("rst_dat", bus.m_dat_o, 0);
        rstn = 1'b1;
        cyc();

        // Read slave 2 with a combinational ack in cycle 1
        master_req(32'hF000_0204, 32'h0, 1'b0, 4'hF);
        cyc(); bus.m_stb_i = 1'b0;
        check("rd2_stb", bus.s_stb_o, 4'b0100);
        check("rd2_adr", bus.s_adr_o, 32'hF000_0204);
        check("rd2_ack_early", bus.m_ack_o, 0);
        bus.s_ack_i[2] = 1'b1;
        bus.s_dat_i[64 +: 32] = 32'hDEAD_BEEF;
        cyc(); bus.s_ack_i = '0;
        check("rd2_ack", bus.m_ack_o, 1);
        check("rd2_err", bus.m_err_o, 0);
        check("rd2_dat", bus.m_dat_o, 32'hDEAD_BEEF);
        check("rd2_stb_drop", bus.s_stb_o, 0);
        cyc();
        check("rd2_ack_once", bus.m_ack_o, 0);
        check("rd2_dat_hold", bus.m_dat_o, 32'hDEAD_BEEF);

        // Write slave 0, ack after 5 cycles; slave 0 read bus carries the same word
        master_req(32'hF000_0010, 32'h1234_5678, 1'b1, 4'b0011);
        bus.s_dat_i[0 +: 32] = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 1) bus.m_stb_i = 1'b0;
            check("wr_stb", bus.s_stb_o, (c == 1) ? 32'h1 : 32'h0);
            check("wr_sdat", bus.s_dat_o, 32'h1234_5678);
            check("wr_ssel", bus.s_sel_o, 4'b0011);
            check("wr_swe", bus.s_we_o, 1);
            check("wr_no_ack", bus.m_ack_o, 0);
            if (c == 5) bus.s_ack_i[0] = 1'b1;
        end
        cyc(); bus.s_ack_i = '0;
        check("wr_ack", bus.m_ack_o, 1);
        check("wr_dat", bus.m_dat_o, 32'hDEAD_BEEF);
        cyc();
        check("wr_ack_once", bus.m_ack_o, 0);

        // Silent slave 1
        master_req(32'hF000_0100, 32'h0, 1'b0, 4'hF);
        pulses = 0;
`ifdef WB_MUX_TIMEOUT_EN
        for (int c = 1; c <= 17; c++) begin
            cyc();
            if (c == 1) bus.m_stb_i = 1'b0;
            pulses += int'(bus.m_ack_o) + int'(bus.m_err_o);
        end
        check("to_quiet", pulses, 0);
        cyc();
        check("to_err", bus.m_err_o, 1);
        check("to_ack", bus.m_ack_o, 0);
        check("to_dat", bus.m_dat_o, 0);
        cyc();
        check("to_err_once", bus.m_err_o, 0);
        cyc();
        bus.s_ack_i[1] = 1'b1;
        bus.s_dat_i[32 +: 32] = 32'hBAD0_BAD0;
        cyc(); bus.s_ack_i = '0;
        check("to_late_ack", bus.m_ack_o, 0);
        cyc();
        check("to_late_ack2", bus.m_ack_o, 0);
        check("to_late_dat", bus.m_dat_o, 0);
`else
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (c == 1) bus.m_stb_i = 1'b0;
            pulses += int'(bus.m_ack_o) + int'(bus.m_err_o);
            if (c == 20) begin
                bus.s_ack_i[1] = 1'b1;
                bus.s_dat_i[32 +: 32] = 32'h0BAD_F00D;
            end
        end
        check("wait_quiet", pulses, 0);
        cyc(); bus.s_ack_i = '0;
        check("wait_ack", bus.m_ack_o, 1);
        check("wait_dat", bus.m_dat_o, 32'h0BAD_F00D);
        cyc();
        check("wait_ack_once", bus.m_ack_o, 0);
`endif

        // Following access to slave 3 completes normally
        master_req(32'hF000_0300, 32'h0, 1'b0, 4'hF);
        cyc(); bus.m_stb_i = 1'b0;
        check("rd3_stb", bus.s_stb_o, 4'b1000);
        bus.s_ack_i[3] = 1'b1;
        bus.s_dat_i[96 +: 32] = 32'hCAFE_F00D;
        cyc(); bus.s_ack_i = '0;
        check("rd3_ack", bus.m_ack_o, 1);
        check("rd3_dat", bus.m_dat_o, 32'hCAFE_F00D);
        cyc();

        // Unmapped accesses
        master_req(32'hF000_0500, 32'h0, 1'b0, 4'hF);
        cyc(); bus.m_stb_i = 1'b0;
        check("miss1_stb", bus.s_stb_o, 0);
        check("miss1_err_early", bus.m_err_o, 0);
        check("miss1_adr", bus.s_adr_o, 32'hF000_0500);
        cyc();
        check("miss1_err", bus.m_err_o, 1);
        check("miss1_ack", bus.m_ack_o, 0);
        check("miss1_dat", bus.m_dat_o, 0);
        cyc();
        check("miss1_err_once", bus.m_err_o, 0);
        master_req(32'h1000_0000, 32'h0, 1'b0, 4'hF);
        cyc(); bus.m_stb_i = 1'b0;
        check("miss2_stb", bus.s_stb_o, 0);
        cyc();
        check("miss2_err", bus.m_err_o, 1);
        check("miss2_dat", bus.m_dat_o, 0);
        cyc();
        check("miss2_err_once", bus.m_err_o, 0);

        // Reset while BUSY
        master_req(32'hF000_0208, 32'h0, 1'b0, 4'hF);
        cyc(); bus.m_stb_i = 1'b0;
        check("rb_stb_pre", bus.s_stb_o, 4'b0100);
        #2 rstn = 1'b0;
        #1;
        check("rb_stb", bus.s_stb_o, 0);
        check("rb_adr", bus.s_adr_o, 0);
        check("rb_ack", bus.m_ack_o, 0);
        check("rb_err", bus.m_err_o, 0);
        cyc();
        rstn = 1'b1;
        bus.s_ack_i[2] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            bus.s_ack_i = '0;
            pulses += int'(bus.m_ack_o) + int'(bus.m_err_o);
        end
        check("rb_no_resp", pulses, 0);
        master_req(32'hF000_0208, 32'h0, 1'b0, 4'hF);
        cyc(); bus.m_stb_i = 1'b0;
        check("rb_next_stb", bus.s_stb_o, 4'b0100);
        bus.s_ack_i[2] = 1'b1;
        bus.s_dat_i[64 +: 32] = 32'h5555_AAAA;
        cyc(); bus.s_ack_i = '0;
        check("rb_next_ack", bus.m_ack_o, 1);
        check("rb_next_dat", bus.m_dat_o, 32'h5555_AAAA);
        cyc();

        // Selected slave acks and errs together; unselected slave 0 acks
        master_req(32'hF000_0104, 32'h0, 1'b0, 4'hF);
        cyc(); bus.m_stb_i = 1'b0;
        bus.s_ack_i = 4'b0011;
        bus.s_err_i = 4'b0010;
        cyc();
        bus.s_ack_i = '0;
        bus.s_err_i = '0;
        check("col_err", bus.m_err_o, 1);
        check("col_ack", bus.m_ack_o, 0);
        check("col_dat", bus.m_dat_o, 0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            pulses += int'(bus.m_ack_o) + int'(bus.m_err_o);
        end
        check("col_single", pulses, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
